// File: rtl/bp_mmu_dual_miss_arbiter.sv
// bp_mmu_dual_miss_arbiter: serialises dual-lane I-TLB misses into single PTW walks and TLB fills.
// Ports: clk_i/reset_n_i (async active-low), flush_i abandons pending work;
//   miss_v_i/miss_vtag_i/miss_ready_o capture per-lane misses (lane 0 in the low slice);
//   ptw_v_o/ptw_vtag_o/ptw_ready_i issue one walk; ptw_resp_v_i/ptw_fault_i/ptw_entry_i return it;
//   tlb_w_v_o/tlb_w_vtag_o/tlb_w_entry_o drive the TLB write port;
//   replay_v_o/fault_v_o pulse per lane; busy_o flags any pending or in-flight work.
// Optional: define BP_MMU_ARB_TIMEOUT_EN to enable the PTW response watchdog (timeout_p cycles).
module bp_mmu_dual_miss_arbiter #(
  parameter int vtag_width_p  = 27,
  parameter int entry_width_p = 40,
  parameter int timeout_p     = 255
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic [1:0]                 miss_v_i,
  input  logic [2*vtag_width_p-1:0]  miss_vtag_i,
  output logic                       miss_ready_o,
  output logic                       ptw_v_o,
  output logic [vtag_width_p-1:0]    ptw_vtag_o,
  input  logic                       ptw_ready_i,
  input  logic                       ptw_resp_v_i,
  input  logic                       ptw_fault_i,
  input  logic [entry_width_p-1:0]   ptw_entry_i,
  output logic                       tlb_w_v_o,
  output logic [vtag_width_p-1:0]    tlb_w_vtag_o,
  output logic [entry_width_p-1:0]   tlb_w_entry_o,
  output logic [1:0]                 replay_v_o,
  output logic [1:0]                 fault_v_o,
  output logic                       busy_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, DONE} state_e;
  state_e                   r_state;
  logic [1:0]               r_pend_v;
  logic [vtag_width_p-1:0]  r_pend_vtag [2];
  logic                     r_sel;
  logic                     r_merge;
  logic                     r_fault;
  logic                     r_drop;
  logic [entry_width_p-1:0] r_entry;
  logic [vtag_width_p-1:0]  w_vtag0, w_vtag1, w_sel_vtag;
  logic [1:0]               w_served;
  logic                     w_merge, w_capture, w_resp, w_timeout;
  assign w_vtag0    = miss_vtag_i[vtag_width_p-1:0];
  assign w_vtag1    = miss_vtag_i[2*vtag_width_p-1:vtag_width_p];
  assign w_sel_vtag = r_pend_vtag[r_sel];
  assign w_merge    = &miss_v_i & (w_vtag0 == w_vtag1);
  assign w_capture  = miss_ready_o & |miss_v_i;
  // a response owed to an abandoned walk must never be taken as the current one
  assign w_resp     = ptw_resp_v_i & ~r_drop;
  assign w_served   = r_merge ? 2'b11 : (r_sel ? 2'b10 : 2'b01);
`ifdef BP_MMU_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  assign w_timeout = (r_state == WAIT) & ~w_resp & (r_cnt == 8'(timeout_p - 1));
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) r_cnt <= '0;
    else r_cnt <= (!flush_i && r_state == WAIT && !w_resp && !w_timeout) ? r_cnt + 8'd1 : 8'd0;
`else
  assign w_timeout = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= IDLE;
      r_pend_v    <= '0;
      r_pend_vtag <= '{default: '0};
      r_sel       <= 1'b0;
      r_merge     <= 1'b0;
      r_fault     <= 1'b0;
      r_drop      <= 1'b0;
      r_entry     <= '0;
    end else if (flush_i) begin
      r_state  <= IDLE;
      r_pend_v <= '0;
      r_merge  <= 1'b0;
      // a walk still outstanding at the PTW will answer later; swallow that answer
      r_drop   <= (r_state == WAIT || r_drop) && !ptw_resp_v_i;
    end else begin
      if (ptw_resp_v_i && r_drop) r_drop <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|r_pend_v) begin
            r_sel   <= ~r_pend_v[0];
            r_state <= REQ;
          end else if (w_capture) begin
            // a merged pair is walked once through slot 0
            r_pend_v       <= w_merge ? 2'b01 : miss_v_i;
            r_pend_vtag[0] <= w_vtag0;
            r_pend_vtag[1] <= w_vtag1;
            r_merge        <= w_merge;
          end
        end
        REQ: if (ptw_ready_i) r_state <= WAIT;
        WAIT: begin
          if (w_resp) begin
            r_entry <= ptw_entry_i;
            r_fault <= ptw_fault_i;
            r_state <= ptw_fault_i ? DONE : FILL;
          end else if (w_timeout) begin
            r_fault <= 1'b1;
            r_drop  <= 1'b1;
            r_state <= DONE;
          end
        end
        FILL: r_state <= DONE;
        DONE: begin
          r_pend_v <= r_pend_v & ~w_served;
          r_merge  <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign miss_ready_o  = (r_state == IDLE) & ~|r_pend_v & ~r_drop;
  assign ptw_v_o       = r_state == REQ;
  assign ptw_vtag_o    = ptw_v_o ? w_sel_vtag : '0;
  assign tlb_w_v_o     = r_state == FILL;
  assign tlb_w_vtag_o  = tlb_w_v_o ? w_sel_vtag : '0;
  assign tlb_w_entry_o = tlb_w_v_o ? r_entry : '0;
  assign replay_v_o    = (r_state == DONE && !r_fault) ? w_served : 2'b00;
  assign fault_v_o     = (r_state == DONE && r_fault) ? w_served : 2'b00;
  assign busy_o        = (r_state != IDLE) | |r_pend_v | r_drop;
endmodule

// File: doc/bp_mmu_dual_miss_arbiter.md
Name: bp_mmu_dual_miss_arbiter

Overview:
- Sequences TLB-miss servicing for the dual-issue instruction MMU.
- Captures per-lane translation misses (lane 0 older, lane 1 younger), merges misses to the same virtual page, and serialises them into one page-table-walker (PTW) request at a time.
- Drives the MMU's single TLB write port with the returned leaf, then signals a per-lane replay to the fetch stage.
- Sits between the dual-issue MMU miss outputs, the shared PTW and the MMU w_v_i/w_vtag_i/w_entry_i port.

Parameters:
vtag_width_p, 27, virtual tag width
entry_width_p, 40, packed PTE-leaf width as consumed by the TLB write port
timeout_p, 255, PTW response watchdog limit in cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush; abandons all pending work
miss_v_i  in  2  per-lane miss strobe, bit0 = lane 0
miss_vtag_i  in  2*vtag_width_p  per-lane missing vtag, lane 0 in the low slice
miss_ready_o  out  1  arbiter can accept new misses
ptw_v_o  out  1  walk request valid
ptw_vtag_o  out  vtag_width_p  vtag to walk
ptw_ready_i  in  1  PTW accepts the request
ptw_resp_v_i  in  1  walk response valid, single-cycle pulse
ptw_fault_i  in  1  walk ended in a page/access fault, qualified by ptw_resp_v_i
ptw_entry_i  in  entry_width_p  leaf PTE, qualified by ptw_resp_v_i
tlb_w_v_o  out  1  TLB write strobe
tlb_w_vtag_o  out  vtag_width_p  TLB write vtag
tlb_w_entry_o  out  entry_width_p  TLB write entry
replay_v_o  out  2  per-lane replay pulse, after a successful fill
fault_v_o  out  2  per-lane fault pulse, after a faulting walk
busy_o  out  1  any pending miss or walk in flight

Behaviour:
- Reset: asynchronous, active-low. While reset_n_i=0:
  - state = IDLE; both pending slots invalid; watchdog counter = 0.
  - All outputs are 0 except miss_ready_o=1.
- Pending storage: two slots, pend_v[1:0] and pend_vtag[1:0]. Slot index equals lane.
- miss_ready_o = (state==IDLE) & ~|pend_v. Misses are captured only on cycles where miss_ready_o=1; miss_v_i is ignored otherwise.
- Merge on capture: if both lanes miss and the vtags are equal:
  - Only slot 0 is walked.
  - A merge flag is stored so that the result pulses both lanes.
- FSM states: IDLE, REQ, WAIT, FILL, DONE.
  - IDLE: if any pend_v is set, select the lowest set slot and go to REQ. Capturing a miss and leaving IDLE take separate cycles, so a miss reaches REQ 1 cycle after capture.
  - REQ: ptw_v_o=1 and ptw_vtag_o=pend_vtag[sel]. Hold ptw_v_o and ptw_vtag_o stable until ptw_ready_i=1, then go to WAIT.
  - WAIT: on ptw_resp_v_i, latch ptw_entry_i and ptw_fault_i.
    - No fault: go to FILL.
    - Fault: go to DONE with fault recorded.
  - FILL: one cycle. tlb_w_v_o=1 with the selected vtag and the latched entry. Go to DONE.
  - DONE: one cycle.
    - Pulse replay_v_o (no fault) or fault_v_o (fault) for the served lane(s). A merge pulses both bits.
    - Clear the served slot(s).
    - Go to IDLE, which picks up slot 1 on the next cycle if it is still pending.
- Latency: capture-to-replay = 1 (IDLE) + REQ cycles + WAIT cycles + FILL + DONE. With zero-wait PTW handshake and a response one cycle after acceptance, replay pulses 5 cycles after capture.
- tlb_w_vtag_o and tlb_w_entry_o read 0 whenever tlb_w_v_o=0.
- ptw_resp_v_i outside WAIT is ignored.
- flush_i (highest priority, takes effect at the next edge):
  - All slots are invalidated and state returns to IDLE.
  - No replay or fault pulses are issued; any TLB write not yet issued is suppressed.
  - If the flush lands in WAIT, the in-flight PTW response is dropped when it arrives: a drop_resp flag is set and cleared on the next ptw_resp_v_i.
  - While drop_resp=1, miss_ready_o=0.
- Simultaneous flush_i and miss_v_i: the flush wins and the miss is not captured.
- Simultaneous ptw_resp_v_i and flush_i in WAIT: the response is discarded and no TLB write occurs.

Optional Feature:
BP_MMU_ARB_TIMEOUT_EN
- Defined:
  - An 8-bit counter increments each cycle in WAIT and clears on leaving WAIT.
  - When the counter reaches timeout_p without a response, go to DONE and pulse fault_v_o for the served lane(s).
  - Set drop_resp so that any late response is discarded.
- Undefined: no counter; WAIT persists until a response or flush.

Test Plan:
- Single lane-0 miss, vtag=0x1234, ptw_ready_i tied 1, response one cycle later with fault=0 and entry=0xAB -> tlb_w_v_o=1 with vtag 0x1234 / entry 0xAB; replay_v_o=2'b01 at capture+5.
- Both lanes miss, vtags 0x10 and 0x20 -> two PTW requests in order 0x10 then 0x20; replay_v_o=2'b01, later 2'b10; miss_ready_o=0 until the second DONE.
- Both lanes miss with the same vtag 0x55 -> exactly one ptw_v_o handshake, one TLB write, replay_v_o=2'b11.
- Lane-1 miss vtag 0x7, response with ptw_fault_i=1 -> no tlb_w_v_o; fault_v_o=2'b10.
- flush_i asserted in WAIT, response arrives 3 cycles later -> no TLB write, no pulses; miss_ready_o returns to 1 the cycle after the dropped response.
- With BP_MMU_ARB_TIMEOUT_EN and timeout_p=4, PTW never responds -> fault_v_o=2'b01 after 4 WAIT cycles; reset_n_i pulsed low mid-WAIT -> all outputs 0 and miss_ready_o=1 immediately, asynchronously.
